// File: rtl/led_fade_driver.sv
// Purpose : 8-channel LED afterglow driver; a lit input snaps its channel to full brightness,
//           which then decays one step every DECAY_DIV enabled cycles, rendered as 16-step PWM.
// Latency : leds_in sampled at edge N loads the level at N; first visible on pwm_out at N+1.
// Backpressure: none; en low freezes all state and forces pwm_out low until en returns.
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - synchronous active-high reset, priority over everything
//   en       - advance enable
//   leds_in  - per-channel on/off pattern (bit i -> channel i)
//   pwm_out  - registered PWM drive (bit i -> channel i)
//   active   - combinational: high while any channel brightness is nonzero
module led_fade_driver #(
  parameter int DECAY_DIV = 4  // enabled cycles per decay step, 1..256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] leds_in,
  output logic [7:0] pwm_out,
  output logic       active
);

  logic [3:0] level [8];
  logic [7:0] dcnt;
  logic [3:0] pwm_cnt;
  logic       tick;

  // DECAY_DIV=256 maps to a terminal count of 255, so 8 bits always suffice.
  assign tick = (dcnt == 8'(DECAY_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        level[i] <= 4'd0;
      end
      dcnt    <= 8'd0;
      pwm_cnt <= 4'd0;
      pwm_out <= 8'h00;
    end else if (en) begin
      dcnt    <= tick ? 8'd0 : dcnt + 8'd1;
      pwm_cnt <= pwm_cnt + 4'd1;  // natural 4-bit wrap gives the 16-cycle period
      for (int i = 0; i < 8; i++) begin
        // Compare uses pre-edge level and counter; level 15 therefore yields 15/16 duty.
        pwm_out[i] <= (level[i] > pwm_cnt);
        if (leds_in[i]) begin
          level[i] <= 4'hF;            // reload wins over a coincident decay tick
        end else if (tick && (level[i] != 4'd0)) begin
          level[i] <= level[i] - 4'd1; // saturate at 0, never wrap
        end
      end
    end else begin
      pwm_out <= 8'h00;
    end
  end

  always_comb begin
    active = 1'b0;
    for (int i = 0; i < 8; i++) begin
      active = active | (level[i] != 4'd0);
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
module tb_led_fade_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] leds_in = 8'h00;
  logic [7:0] pwm_out, pwm1;
  logic       active, active1;

  always #5 clk = ~clk;

  led_fade_driver #(.DECAY_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .leds_in(leds_in), .pwm_out(pwm_out), .active(active)
  );

  led_fade_driver #(.DECAY_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .leds_in(leds_in), .pwm_out(pwm1), .active(active1)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] leds;
    logic [7:0] exp_pwm;
    logic       exp_act;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  // Drive inputs, take one rising edge, then settle 1 time unit before sampling.
  task automatic step(input logic r, input logic e, input logic [7:0] l);
    rst = r; en = e; leds_in = l;
    @(posedge clk);
    #1;
  endtask

  // Expected brightness after k enabled edges of a single pulse on edge 1 followed by zeros.
  // Ticks fall on edges that are multiples of div; the tick on edge 1 (div=1) is
  // overridden by the reload.
  function automatic int lvl_after(input int k, input int div);
    int ticks;
    if (k < 1) return 0;
    ticks = k / div - ((div == 1) ? 1 : 0);
    return (ticks >= 15) ? 0 : 15 - ticks;
  endfunction

  // Expected pwm_out[0] after enabled edge k of the single-pulse fade.
  function automatic logic fade_bit(input int k, input int div);
    return (lvl_after(k - 1, div) > ((k - 1) % 16));
  endfunction

  initial begin
    // ---------------- table-driven vectors (DECAY_DIV=4) ----------------
    vt[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0}; // reset state
    vt[1] = '{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1}; // levels load, pwm sees pre-edge 0
    vt[2] = '{1'b0, 1'b1, 8'h00, 8'hFF, 1'b1}; // 15 > 1
    vt[3] = '{1'b0, 1'b1, 8'h0F, 8'hFF, 1'b1}; // 15 > 2
    vt[4] = '{1'b0, 1'b1, 8'h0F, 8'hFF, 1'b1}; // tick: ch4-7 -> 14, ch0-3 reload
    vt[5] = '{1'b0, 1'b0, 8'hAA, 8'h00, 1'b1}; // disabled: output forced low
    vt[6] = '{1'b0, 1'b0, 8'h55, 8'h00, 1'b1};
    vt[7] = '{1'b0, 1'b1, 8'h00, 8'hFF, 1'b1}; // 15/14 > 4
    vt[8] = '{1'b1, 1'b1, 8'hFF, 8'h00, 1'b0}; // reset beats en and leds_in
    vt[9] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0}; // all levels were cleared
    for (int i = 0; i < 10; i++) begin
      step(vt[i].rst, vt[i].en, vt[i].leds);
      check($sformatf("vec%0d_pwm", i), pwm_out, vt[i].exp_pwm);
      check($sformatf("vec%0d_active", i), {7'd0, active}, {7'd0, vt[i].exp_act});
    end

    // ---------------- single-pulse fade ----------------
    step(1'b1, 1'b0, 8'h00);
    for (int k = 1; k <= 64; k++) begin
      step(1'b0, 1'b1, (k == 1) ? 8'h01 : 8'h00);
      check($sformatf("fade_pwm_e%0d", k), pwm_out, {7'd0, fade_bit(k, 4)});
      check($sformatf("fade_active_e%0d", k), {7'd0, active}, {7'd0, (k < 60)});
    end

    // ---------------- enable gating mid-fade ----------------
    step(1'b1, 1'b0, 8'h00);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1, (k == 1) ? 8'h01 : 8'h00);
    end
    for (int j = 0; j < 10; j++) begin
      step(1'b0, 1'b0, (j % 2 == 0) ? 8'hFF : 8'h00);
      check($sformatf("gate_pwm_d%0d", j), pwm_out, 8'h00);
      check($sformatf("gate_active_d%0d", j), {7'd0, active}, 8'h01);
    end
    for (int k = 11; k <= 30; k++) begin
      step(1'b0, 1'b1, 8'h00);
      check($sformatf("gate_resume_e%0d", k), pwm_out, {7'd0, fade_bit(k, 4)});
    end

    // ---------------- reload versus tick ----------------
    step(1'b1, 1'b0, 8'h00);
    for (int k = 1; k <= 50; k++) begin
      step(1'b0, 1'b1, (k == 1) ? 8'h01 : 8'h00);
    end
    step(1'b0, 1'b1, 8'h00);           // edge 51: level 3 > pwm_cnt 2
    check("reload_pre_e51", pwm_out, 8'h01);
    step(1'b0, 1'b1, 8'h01);           // edge 52: tick edge, reload; 3 > 3 false
    check("reload_tick_e52", pwm_out, 8'h00);
    step(1'b0, 1'b1, 8'h00);           // edge 53: level 15 > 4 (decay would give 2)
    check("reload_post_e53", pwm_out, 8'h01);
    step(1'b0, 1'b1, 8'h00);           // edge 54: 15 > 5
    check("reload_post_e54", pwm_out, 8'h01);

    // ---------------- reset mid-operation, then steady-on duty ----------------
    step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'hFF);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 8'h00);
    check("midrst_before_active", {7'd0, active}, 8'h01);
    step(1'b1, 1'b1, 8'hFF);
    check("midrst_pwm", pwm_out, 8'h00);
    check("midrst_active", {7'd0, active}, 8'h00);
    for (int k = 1; k <= 33; k++) begin
      step(1'b0, 1'b1, 8'hFF);
      check($sformatf("steady_pwm_e%0d", k), pwm_out,
            ((k == 1) || ((k - 1) % 16 == 15)) ? 8'h00 : 8'hFF);
      check($sformatf("steady_active_e%0d", k), {7'd0, active}, 8'h01);
    end

    // ---------------- DECAY_DIV=1 fade and saturation ----------------
    step(1'b1, 1'b0, 8'h00);
    check("div1_reset_active", {7'd0, active1}, 8'h00);
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 1'b1, (k == 1) ? 8'h01 : 8'h00);
      check($sformatf("div1_pwm_e%0d", k), pwm1, {7'd0, fade_bit(k, 1)});
      check($sformatf("div1_active_e%0d", k), {7'd0, active1}, {7'd0, (k < 16)});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
